// File: rtl/mem_arb_pkg.sv
// Purpose     : shared types and default widths for the memory-port arbiter.
// Latency     : n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_W     = 128;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Purpose     : picks the next owner of the memory port; dcache first, icache starvation bounded by a streak count.
// Latency     : grant/owner are combinational from the request inputs; the streak updates on the granting edge.
// Backpressure: grants only while idle is high; a flushed icache request is never granted.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   idle              arbiter can accept a new transaction this cycle
//   ic_req, dc_req    pending requests from the two caches
//   flush             pipeline flush, masks the icache request
//   grant, owner      a transaction starts on this edge, and who owns it
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   idle,
    input  logic   ic_req,
    input  logic   dc_req,
    input  logic   flush,
    output logic   grant,
    output owner_t owner
);

    localparam int             SW      = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  MAX_CNT = SW'(STARVE_MAX);

    // Number of consecutive dcache grants made while the icache was waiting.
    logic [SW-1:0] streak;
    logic          ic_ok;

    always_comb begin
        ic_ok = ic_req && !flush;
        grant = 1'b0;
        owner = OWN_DC;
        if (idle) begin
            // Once the streak hits the bound a waiting icache request jumps the queue.
            if (dc_req && !(ic_ok && streak == MAX_CNT)) begin
                grant = 1'b1;
                owner = OWN_DC;
            end else if (ic_ok) begin
                grant = 1'b1;
                owner = OWN_IC;
            end
        end
    end

    // The streak counts against the raw icache request: a flushed icache
    // request is still considered waiting for fairness purposes.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if (owner == OWN_IC || !ic_req) begin
                streak <= '0;
            end else if (streak != MAX_CNT) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose     : shares the single main-memory line port between icache fills and dcache fills/writebacks.
// Latency     : request sampled at edge k -> strobes from k+1; done one cycle after mem_ready (2 cycles minimum).
// Backpressure: one line in flight; requesters hold req until their done pulse, dcache wins unless icache starved.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   flush                             cancels icache traffic (grant blocked, done/rdata suppressed)
//   ic_req, ic_addr                   icache line read request
//   ic_done, ic_rdata                 icache completion pulse and returned line
//   dc_req, dc_we, dc_addr, dc_wdata  dcache fill (we=0) or writeback (we=1) request
//   dc_done, dc_rdata                 dcache completion pulse and returned line
//   mem_read, mem_write, mem_addr,
//   mem_wdata                         registered memory command, held until mem_ready
//   mem_ready, mem_rdata              one-cycle memory completion and read line
//   busy                              a transaction is in progress
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,

    output logic              busy
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } line_req_t;

    state_t    state;
    state_t    state_nxt;
    owner_t    owner;
    owner_t    grant_owner;
    logic      grant;
    line_req_t sel_req;

    // Set once a flush is seen while the icache owns the port; the memory
    // transaction still runs to completion but its result is dropped.
    logic      ic_cancel;
    logic      ic_done_r;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .idle   (state == IDLE),
        .ic_req (ic_req),
        .dc_req (dc_req),
        .flush  (flush),
        .grant  (grant),
        .owner  (grant_owner)
    );

    // Request selected by the arbiter; the icache only ever reads.
    always_comb begin
        sel_req.we    = 1'b0;
        sel_req.addr  = ic_addr;
        sel_req.wdata = '0;
        if (grant_owner == OWN_DC) begin
            sel_req.we    = dc_we;
            sel_req.addr  = dc_addr;
            sel_req.wdata = dc_we ? dc_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = MEM;
            MEM:     if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_IC;
            ic_cancel <= 1'b0;
            ic_done_r <= 1'b0;
            dc_done   <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ic_done_r <= 1'b0;
            dc_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= grant_owner;
                        ic_cancel <= 1'b0;
                        mem_read  <= !sel_req.we;
                        mem_write <= sel_req.we;
                        mem_addr  <= sel_req.addr;
                        mem_wdata <= sel_req.wdata;
                    end
                end
                MEM: begin
                    if (owner == OWN_IC && flush) begin
                        ic_cancel <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (owner == OWN_DC) begin
                            dc_done <= 1'b1;
                            // mem_write still reflects the command being completed.
                            if (!mem_write) begin
                                dc_rdata <= mem_rdata;
                            end
                        end else if (!ic_cancel && !flush) begin
                            ic_done_r <= 1'b1;
                            ic_rdata  <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A flush arriving in the response cycle still has to kill the pulse,
    // which is too late for the register, so it is masked on the way out.
    assign ic_done = ic_done_r && !flush;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 128;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset, flush;
    logic              ic_req, dc_req, dc_we, mem_ready;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [LINE_W-1:0] dc_wdata, mem_rdata;
    logic              ic_done, dc_done, mem_read, mem_write, busy;
    logic [LINE_W-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .LINE_W     (LINE_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_done   (ic_done),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_done   (dc_done),
        .dc_rdata  (dc_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit                m_act, m_resp, m_resp_ic, m_resp_dc, m_own_ic, m_we, m_cancel;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata, m_ic_rdata, m_dc_rdata;
    int                m_streak;
    int                mem_cnt, mem_wait;

    // ---------------- requesters, memory stimulus, observation ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [LINE_W-1:0] wdata;
    } dreq_t;

    logic [ADDR_W-1:0] ic_q[$];
    dreq_t             dc_q[$];
    logic [ADDR_W-1:0] cmd_log[$];
    logic [LINE_W-1:0] wdat_log[$];
    int  wait_cfg, idle_ready;
    bit  rand_rdata, ic_fin, dc_fin, prev_strobe;
    int  cyc, ic_done_cnt, dc_done_cnt, ic_done_cyc, dc_first_done, adj_strobe;

    task automatic clear_logs();
        cmd_log.delete();
        wdat_log.delete();
        ic_done_cnt   = 0;
        dc_done_cnt   = 0;
        ic_done_cyc   = -1;
        dc_first_done = -1;
        adj_strobe    = 0;
    endtask

    task automatic check_cycle();
        bit exp_icd, strobe;
        exp_icd = m_resp_ic && !flush;
        check("ic_done", ic_done, exp_icd);
        check("dc_done", dc_done, m_resp_dc);
        check("busy", busy, m_act || m_resp);
        check("mem_read", mem_read, m_act && !m_we);
        check("mem_write", mem_write, m_act && m_we);
        if (m_act) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_we ? m_wdata : '0);
        end
        check("ic_rdata", ic_rdata, m_ic_rdata);
        check("dc_rdata", dc_rdata, m_dc_rdata);
        ic_fin = exp_icd;
        dc_fin = m_resp_dc;
        if (ic_done === 1'b1) begin
            ic_done_cnt++;
            ic_done_cyc = cyc;
        end
        if (dc_done === 1'b1) begin
            dc_done_cnt++;
            if (dc_first_done < 0) dc_first_done = cyc;
        end
        strobe = (mem_read === 1'b1) || (mem_write === 1'b1);
        if (strobe && !prev_strobe) begin
            cmd_log.push_back(mem_addr);
            wdat_log.push_back(mem_wdata);
        end
        if (strobe && prev_strobe) adj_strobe++;
        prev_strobe = strobe;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic step_model();
        bit ic_ok;
        m_resp_ic = 1'b0;
        m_resp_dc = 1'b0;
        if (reset) begin
            m_act = 0; m_resp = 0; m_cancel = 0; m_streak = 0;
            m_ic_rdata = '0; m_dc_rdata = '0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_act) begin
            mem_cnt++;
            if (m_own_ic && flush) m_cancel = 1'b1;
            if (mem_ready) begin
                m_act  = 1'b0;
                m_resp = 1'b1;
                if (m_own_ic) begin
                    if (!m_cancel) begin
                        m_resp_ic  = 1'b1;
                        m_ic_rdata = mem_rdata;
                    end
                end else begin
                    m_resp_dc = 1'b1;
                    if (!m_we) m_dc_rdata = mem_rdata;
                end
            end
        end else begin
            ic_ok = ic_req && !flush;
            if (dc_req && !(ic_ok && m_streak == STARVE_MAX)) begin
                m_act = 1; m_own_ic = 0; m_we = dc_we; m_addr = dc_addr; m_wdata = dc_wdata;
                if (!ic_req) m_streak = 0;
                else if (m_streak < STARVE_MAX) m_streak++;
            end else if (ic_ok) begin
                m_act = 1; m_own_ic = 1; m_we = 0; m_addr = ic_addr; m_wdata = '0;
                m_streak = 0;
            end
            if (m_act) begin
                m_cancel = 1'b0;
                mem_cnt  = 0;
                mem_wait = (wait_cfg < 0) ? int'($urandom_range(0, 4)) : wait_cfg;
            end
        end
    endtask

    task automatic present();
        ic_req   = (ic_q.size() > 0);
        ic_addr  = ic_req ? ic_q[0] : '0;
        dc_req   = (dc_q.size() > 0);
        dc_we    = dc_req ? dc_q[0].we : 1'b0;
        dc_addr  = dc_req ? dc_q[0].addr : '0;
        dc_wdata = dc_req ? dc_q[0].wdata : '0;
    endtask

    task automatic drive_mem();
        if (m_act) mem_ready = (mem_cnt >= mem_wait);
        else if (idle_ready == 2) mem_ready = 1'b1;
        else if (idle_ready == 1) mem_ready = ($urandom_range(0, 3) == 0);
        else mem_ready = 1'b0;
        if (rand_rdata) mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a falling edge: check this cycle late, cross the edge, drive the next cycle.
    task automatic advance();
        #4;
        check_cycle();
        step_model();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ic_fin && ic_q.size() > 0) void'(ic_q.pop_front());
        if (dc_fin && dc_q.size() > 0) void'(dc_q.pop_front());
        drive_mem();
        present();
    endtask

    task automatic do_flush(input bit f, input bit drop);
        flush = f;
        if (f && drop) begin
            ic_q.delete();
            ic_req = 1'b0;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        flush = 1'b0;
        ic_q.delete();
        dc_q.delete();
        present();
        advance();
        reset = 1'b0;
    endtask

    task automatic push_dc(input logic [ADDR_W-1:0] a, input bit we, input logic [LINE_W-1:0] d);
        dreq_t r;
        r.addr = a; r.we = we; r.wdata = d;
        dc_q.push_back(r);
    endtask

    function automatic logic [ADDR_W-1:0] log_at(input int i);
        return (i < cmd_log.size()) ? cmd_log[i] : '1;
    endfunction

    initial begin
        logic [ADDR_W-1:0] starve_order [7];
        int req_cyc;

        reset = 1'b1; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        m_act = 0; m_resp = 0; m_resp_ic = 0; m_resp_dc = 0; m_own_ic = 0; m_we = 0; m_cancel = 0;
        m_addr = '0; m_wdata = '0; m_ic_rdata = '0; m_dc_rdata = '0; m_streak = 0;
        mem_cnt = 0; mem_wait = 0; wait_cfg = 0; idle_ready = 0; rand_rdata = 0;
        ic_fin = 0; dc_fin = 0; prev_strobe = 0; cyc = 0;
        clear_logs();
        @(negedge clk);

        // Reset state
        reset_dut();
        check("rst_busy", busy, 1'b0);
        check("rst_ic_rdata", ic_rdata, '0);

        // Basic icache read, memory answers 3 cycles after the strobe rises
        wait_cfg = 3; mem_rdata = 128'h0181;
        reset_dut();
        clear_logs();
        ic_q.push_back(32'h40); present();
        req_cyc = cyc;
        repeat (8) advance();
        check("basic_addr", log_at(0), 32'h40);
        check("basic_rdata", ic_rdata, 128'h0181);
        check("basic_latency", ic_done_cyc - req_cyc, 5);
        check("basic_done_cnt", ic_done_cnt, 1);

        // Priority: dc writeback and ic read in the same cycle
        wait_cfg = 1; mem_rdata = 128'h0777;
        reset_dut();
        clear_logs();
        ic_q.push_back(32'h40);
        push_dc(32'h80, 1'b1, 128'h0381);
        present();
        repeat (12) advance();
        check("prio_first", log_at(0), 32'h80);
        check("prio_wdata", (wdat_log.size() > 0) ? wdat_log[0] : '1, 128'h0381);
        check("prio_second", log_at(1), 32'h40);
        check("prio_dc_rdata", dc_rdata, '0);
        check("prio_dones", ic_done_cnt + dc_done_cnt, 2);

        // Starvation bound: ic held, six back-to-back dc requests
        wait_cfg = -1; rand_rdata = 1;
        reset_dut();
        clear_logs();
        ic_q.push_back(32'h40);
        for (int i = 0; i < 6; i++) push_dc(32'h100 + 32'(16 * i), i[0], 128'(i + 1));
        present();
        repeat (60) advance();
        starve_order = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h40, 32'h140, 32'h150};
        check("starve_count", cmd_log.size(), 7);
        for (int i = 0; i < 7; i++) check($sformatf("starve_order%0d", i), log_at(i), starve_order[i]);

        // Flush while an icache read is in MEM
        wait_cfg = 3; rand_rdata = 0; mem_rdata = 128'h0181;
        reset_dut();
        ic_q.push_back(32'h40); present();
        repeat (8) advance();
        clear_logs();
        mem_rdata = 128'h5555;
        ic_q.push_back(32'h60); present();
        repeat (2) advance();
        do_flush(1'b1, 1'b1);
        advance();
        do_flush(1'b0, 1'b0);
        push_dc(32'h90, 1'b0, '0); present();
        repeat (14) advance();
        check("flush_ic_done", ic_done_cnt, 0);
        check("flush_ic_rdata", ic_rdata, 128'h0181);
        check("flush_dc_done", dc_done_cnt, 1);
        check("flush_dc_rdata", dc_rdata, 128'h5555);
        check("flush_cmds", {log_at(0), log_at(1)}, {32'h60, 32'h90});

        // Reset in the middle of a writeback
        wait_cfg = 4;
        reset_dut();
        clear_logs();
        push_dc(32'ha0, 1'b1, 128'hbeef); present();
        repeat (2) advance();
        check("midrst_busy_before", busy, 1'b1);
        reset_dut();
        check("midrst_busy", busy, 1'b0);
        check("midrst_write", mem_write, 1'b0);
        check("midrst_addr", mem_addr, '0);
        check("midrst_wdata", mem_wdata, '0);
        repeat (8) advance();
        check("midrst_no_done", dc_done_cnt + ic_done_cnt, 0);

        // Zero-wait memory, mem_ready tied high
        wait_cfg = 0; idle_ready = 2; rand_rdata = 1;
        reset_dut();
        clear_logs();
        for (int i = 0; i < 3; i++) push_dc(32'h200 + 32'(16 * i), 1'b0, '0);
        present();
        req_cyc = cyc;
        repeat (12) advance();
        check("zw_latency", dc_first_done - req_cyc, 2);
        check("zw_gap", adj_strobe, 0);
        check("zw_dones", dc_done_cnt, 3);

        // Randomized traffic
        wait_cfg = -1; idle_ready = 1;
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            advance();
            if ($urandom_range(0, 599) == 0) reset_dut();
            if (ic_q.size() == 0 && $urandom_range(0, 3) == 0)
                ic_q.push_back({$urandom_range(0, 32'h0fff_ffff), 4'h0});
            if (dc_q.size() == 0 && $urandom_range(0, 2) == 0)
                push_dc({$urandom_range(0, 32'h0fff_ffff), 4'h0}, 1'($urandom),
                        {$urandom, $urandom, $urandom, $urandom});
            present();
            if ($urandom_range(0, 19) == 0) do_flush(1'b1, 1'($urandom));
            else do_flush(1'b0, 1'b0);
        end
        do_flush(1'b0, 1'b0);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
